// File: rtl/urv_exec_divider.sv
// urv_exec_divider: multi-cycle restoring divider for RV32M/RV64M DIV/DIVU/REM/REMU in exec.
// Optional feature macro: URV_DIV_EARLY_OUT_EN (skip iteration for zero divisor, overflow, |rs1|<|rs2|).
module urv_exec_divider #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            x_stall_i,
    input  logic            x_kill_i,
    output logic            x_stall_req_o,
    input  logic            d_valid_i,
    input  logic            d_is_divide_i,
    input  logic [2:0]      d_fun_i,
    input  logic [XLEN-1:0] d_rs1_i,
    input  logic [XLEN-1:0] d_rs2_i,
    output logic [XLEN-1:0] x_rd_o,
    output logic            x_done_o
);
    localparam int unsigned N_ITER = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W  = $clog2(N_ITER + 1);
    localparam int unsigned MAG_W  = XLEN + 1;
    localparam logic [XLEN-1:0] INT_MIN = XLEN'(1) << (XLEN - 1);
`ifdef URV_DIV_EARLY_OUT_EN
    localparam bit EARLY_OUT_EN = 1'b1;
`else
    localparam bit EARLY_OUT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t           state_r, state_nx;
    logic [CNT_W-1:0] cnt_r, cnt_nx;
    logic [XLEN-1:0]  quo_r, quo_nx;
    logic [MAG_W-1:0] rem_r, rem_nx;
    logic [MAG_W-1:0] den_r, den_nx;
    logic             is_rem_r, is_rem_nx;
    logic             neg_q_r, neg_q_nx;
    logic             neg_r_r, neg_r_nx;
    logic             div0_r, div0_nx;
    logic             ovf_r, ovf_nx;
    logic [XLEN-1:0]  rd_r, rd_nx;
    logic             done_r, done_nx;

    // Operand decode, only meaningful in the start cycle
    logic             start, op_signed, rs1_neg, rs2_neg, div0, ovf, mag_lt, early_out;
    logic [MAG_W-1:0] rs1_mag, rs2_mag;
    logic             unused_fun;

    assign unused_fun = d_fun_i[2];
    assign start      = d_valid_i & d_is_divide_i & ~x_kill_i & (state_r == IDLE);
    assign op_signed  = ~d_fun_i[0];
    assign rs1_neg    = op_signed & d_rs1_i[XLEN-1];
    assign rs2_neg    = op_signed & d_rs2_i[XLEN-1];
    assign rs1_mag    = rs1_neg ? MAG_W'(0) - {1'b1, d_rs1_i} : {1'b0, d_rs1_i};
    assign rs2_mag    = rs2_neg ? MAG_W'(0) - {1'b1, d_rs2_i} : {1'b0, d_rs2_i};
    assign div0       = (d_rs2_i == '0);
    assign ovf        = op_signed & (d_rs1_i == INT_MIN) & (d_rs2_i == '1);
    assign mag_lt     = (rs1_mag < rs2_mag);
    assign early_out  = EARLY_OUT_EN & (div0 | ovf | mag_lt);

    assign x_stall_req_o = ~x_kill_i & (start | (state_r == ITER) | (state_r == FIX));
    assign x_rd_o        = rd_r;
    assign x_done_o      = done_r;

    // Restoring division step, BITS_PER_CYCLE quotient bits MSB first
    logic [MAG_W-1:0] it_rem, it_shift;
    logic [XLEN-1:0]  it_quo;
    always_comb begin
        it_rem   = rem_r;
        it_quo   = quo_r;
        it_shift = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            it_shift = {it_rem[XLEN-1:0], it_quo[XLEN-1]};
            it_quo   = {it_quo[XLEN-2:0], (it_shift >= den_r)};
            it_rem   = (it_shift >= den_r) ? it_shift - den_r : it_shift;
        end
    end

    // Sign correction and RISC-V special cases
    logic [XLEN-1:0] q_fix, r_fix, fix_result;
    always_comb begin
        q_fix = neg_q_r ? XLEN'(0) - quo_r : quo_r;
        r_fix = neg_r_r ? XLEN'(0) - rem_r[XLEN-1:0] : rem_r[XLEN-1:0];
        if (div0_r) begin
            q_fix = '1;
        end
        if (ovf_r) begin
            q_fix = INT_MIN;
            r_fix = '0;
        end
        fix_result = is_rem_r ? r_fix : q_fix;
    end

    always_comb begin
        state_nx  = state_r;
        cnt_nx    = cnt_r;
        quo_nx    = quo_r;
        rem_nx    = rem_r;
        den_nx    = den_r;
        is_rem_nx = is_rem_r;
        neg_q_nx  = neg_q_r;
        neg_r_nx  = neg_r_r;
        div0_nx   = div0_r;
        ovf_nx    = ovf_r;
        rd_nx     = rd_r;
        unique case (state_r)
            IDLE: begin
                if (start) begin
                    is_rem_nx = d_fun_i[1];
                    neg_q_nx  = rs1_neg ^ rs2_neg;
                    neg_r_nx  = rs1_neg;
                    div0_nx   = div0;
                    ovf_nx    = ovf;
                    den_nx    = rs2_mag;
                    cnt_nx    = CNT_W'(N_ITER);
                    if (early_out) begin
                        quo_nx   = '0;
                        rem_nx   = rs1_mag;
                        state_nx = FIX;
                    end else begin
                        quo_nx   = rs1_mag[XLEN-1:0];
                        rem_nx   = '0;
                        state_nx = ITER;
                    end
                end
            end
            ITER: begin
                quo_nx = it_quo;
                rem_nx = it_rem;
                cnt_nx = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                rd_nx    = fix_result;
                state_nx = DONE;
            end
            DONE: begin
                if (!x_stall_i) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // A flush abandons the operation and leaves the last result untouched
        if ((state_r != IDLE) && x_kill_i) begin
            state_nx = IDLE;
            rd_nx    = rd_r;
        end
        done_nx = (state_nx == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            quo_r    <= '0;
            rem_r    <= '0;
            den_r    <= '0;
            is_rem_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            div0_r   <= 1'b0;
            ovf_r    <= 1'b0;
            rd_r     <= '0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nx;
            cnt_r    <= cnt_nx;
            quo_r    <= quo_nx;
            rem_r    <= rem_nx;
            den_r    <= den_nx;
            is_rem_r <= is_rem_nx;
            neg_q_r  <= neg_q_nx;
            neg_r_r  <= neg_r_nx;
            div0_r   <= div0_nx;
            ovf_r    <= ovf_nx;
            rd_r     <= rd_nx;
            done_r   <= done_nx;
        end
    end

endmodule

// File: tb/tb_urv_exec_divider.sv
// Bench for urv_exec_divider: BPC=1 and BPC=2 instances share stimulus and are checked
// every cycle against an arithmetic reference with a latency-only timing model.
module tb_urv_exec_divider;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n, x_stall, x_kill, d_valid, d_div;
    logic [2:0]  d_fun;
    logic [31:0] d_rs1, d_rs2;
    logic [1:0]  stall_req, done;
    logic [31:0] rd [2];

    always #5 clk = ~clk;

    urv_exec_divider #(.XLEN(32), .BITS_PER_CYCLE(1)) u_div_r1 (
        .clk_i(clk), .rst_n_i(rst_n), .x_stall_i(x_stall), .x_kill_i(x_kill),
        .x_stall_req_o(stall_req[0]), .d_valid_i(d_valid), .d_is_divide_i(d_div),
        .d_fun_i(d_fun), .d_rs1_i(d_rs1), .d_rs2_i(d_rs2), .x_rd_o(rd[0]), .x_done_o(done[0]));

    urv_exec_divider #(.XLEN(32), .BITS_PER_CYCLE(2)) u_div_r2 (
        .clk_i(clk), .rst_n_i(rst_n), .x_stall_i(x_stall), .x_kill_i(x_kill),
        .x_stall_req_o(stall_req[1]), .d_valid_i(d_valid), .d_is_divide_i(d_div),
        .d_fun_i(d_fun), .d_rs1_i(d_rs1), .d_rs2_i(d_rs2), .x_rd_o(rd[1]), .x_done_o(done[1]));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result straight from the RISC-V definition
    function automatic logic [31:0] ref_div(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return fun[1] ? a : 32'hFFFF_FFFF;
        if (!fun[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return fun[1] ? 32'(r) : 32'(q);
    endfunction

    // Cycles from accepted start to DONE
    function automatic int lat_of(input int k, input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb;
        bit sgn, ovf;
        sgn = !fun[0];
        ma  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        mb  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        ovf = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`ifdef URV_DIV_EARLY_OUT_EN
        if (b == 32'd0 || ovf || ma < mb) return 2;
`endif
        if (ovf && ma < mb) return 0;
        return (k == 0 ? 32 : 16) + 2;
    endfunction

    bit          m_busy [2];
    int          m_ph   [2];
    int          m_lat  [2];
    logic [31:0] m_res  [2];
    logic [31:0] m_held [2];
    int          stall_tot [2];

    // Timing model: m_ph counts cycles since the accepted start
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] = 1'b0;
                m_ph[k]   = 0;
                m_held[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!m_busy[k]) begin
                    if (d_valid && d_div && !x_kill) begin
                        m_busy[k] = 1'b1;
                        m_ph[k]   = 1;
                        m_lat[k]  = lat_of(k, d_fun, d_rs1, d_rs2);
                        m_res[k]  = ref_div(d_fun, d_rs1, d_rs2);
                    end
                end else if (x_kill) begin
                    m_busy[k] = 1'b0;
                end else if (m_ph[k] >= m_lat[k]) begin
                    if (!x_stall) m_busy[k] = 1'b0;
                end else begin
                    if (m_ph[k] == m_lat[k] - 1) m_held[k] = m_res[k];
                    m_ph[k]++;
                end
            end
        end
    end

    // Per-cycle compare
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic e_stall, e_done;
            e_done  = m_busy[k] && (m_ph[k] >= m_lat[k]);
            e_stall = !x_kill && ((m_busy[k] && m_ph[k] < m_lat[k]) || (!m_busy[k] && d_valid && d_div));
            chk($sformatf("stall_req[%0d]", k), 64'(stall_req[k]), 64'(e_stall));
            chk($sformatf("done[%0d]", k), 64'(done[k]), 64'(e_done));
            chk($sformatf("rd[%0d]", k), 64'(rd[k]), 64'(m_held[k]));
            stall_tot[k] += int'(stall_req[k]);
        end
    end

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'($urandom_range(1, 15));
            4: v = 32'd0 - 32'($urandom_range(1, 15));
            5: v = 32'($urandom_range(0, 65535));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic run_op(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b,
                          input int kill_at, input int hold,
                          output int dat0, output int dat1, output int st0, output int st1);
        int s0b, s1b, hl;
        bit fin;
        s0b = stall_tot[0];
        s1b = stall_tot[1];
        dat0 = -1;
        dat1 = -1;
        hl = hold;
        fin = 1'b0;
        d_valid = 1'b1; d_div = 1'b1; d_fun = fun; d_rs1 = a; d_rs2 = b;
        x_kill = 1'b0; x_stall = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            d_valid = 1'b0;
            d_div   = 1'($urandom_range(0, 1));
            d_fun   = 3'($urandom);
            d_rs1   = $urandom;
            d_rs2   = $urandom;
            if (done[0] && dat0 < 0) dat0 = c;
            if (done[1] && dat1 < 0) dat1 = c;
            if (!m_busy[0] && !m_busy[1]) begin
                fin = 1'b1;
                break;
            end
            x_kill = (c == kill_at);
            if (m_busy[0] && m_ph[0] >= m_lat[0] && m_busy[1] && m_ph[1] >= m_lat[1]) begin
                if (hl > 0) begin
                    hl--;
                    x_stall = 1'b1;
                end else begin
                    x_stall = 1'b0;
                end
            end else begin
                x_stall = 1'b1;
            end
        end
        if (!fin) chk("op_timeout", 64'd1, 64'd0);
        x_kill = 1'b0;
        x_stall = 1'b0;
        st0 = stall_tot[0] - s0b;
        st1 = stall_tot[1] - s1b;
    endtask

    task automatic op_lit(input string name, input logic [2:0] fun, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int d0, d1, s0, s1;
        run_op(fun, a, b, -1, 0, d0, d1, s0, s1);
        chk({name, "_r1"}, 64'(rd[0]), 64'(exp));
        chk({name, "_r2"}, 64'(rd[1]), 64'(exp));
    endtask

    initial begin
        int d0, d1, s0, s1;
        stall_tot[0] = 0; stall_tot[1] = 0;
        rst_n = 1'b0; x_stall = 1'b0; x_kill = 1'b0; d_valid = 1'b0; d_div = 1'b0;
        d_fun = 3'd0; d_rs1 = '0; d_rs2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {rd[0], rd[1]} ^ 64'({stall_req, done}), 64'd0);
        rst_n = 1'b1;

        // Full-latency DIV with exact stall and done timing
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, -1, 0, d0, d1, s0, s1);
        chk("div_m7_2_r1", 64'(rd[0]), 64'hFFFF_FFFD);
        chk("div_m7_2_r2", 64'(rd[1]), 64'hFFFF_FFFD);
        chk("stall_len_r1", 64'(s0), 64'd34);
        chk("stall_len_r2", 64'(s1), 64'd18);
        chk("done_at_r1", 64'(d0), 64'd34);
        chk("done_at_r2", 64'(d1), 64'd18);

        op_lit("rem_m7_2", F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        op_lit("remu_fff9_2", F_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1);
        op_lit("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14);
        op_lit("divu_by0", F_DIVU, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF);
        op_lit("rem_by0", F_REM, 32'd5, 32'd0, 32'd5);
        op_lit("div_m5_by0", F_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        op_lit("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        op_lit("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // DONE held under stall for several cycles
        run_op(F_DIVU, 32'd1000, 32'd3, -1, 5, d0, d1, s0, s1);
        chk("divu_1000_3_r1", 64'(rd[0]), 64'd333);
        chk("divu_1000_3_r2", 64'(rd[1]), 64'd333);
        chk("stall_1000_r2", 64'(s1), 64'd18);

        // Back-to-back signed divides
        op_lit("b2b_a", F_DIV, 32'd0 - 32'd100, 32'd7, 32'hFFFF_FFF2);
        op_lit("b2b_b", F_DIV, 32'd77, 32'd0 - 32'd5, 32'hFFFF_FFF1);

        // Kill in the 5th ITER cycle: result keeps the previous value
        run_op(F_DIVU, 32'd999, 32'd10, 5, 0, d0, d1, s0, s1);
        chk("kill_rd_r1", 64'(rd[0]), 64'hFFFF_FFF1);
        chk("kill_rd_r2", 64'(rd[1]), 64'hFFFF_FFF1);
        chk("kill_stall_r1", 64'(s0), 64'd5);
        chk("kill_stall_r2", 64'(s1), 64'd5);

        // Reset mid-ITER clears outputs immediately
        d_valid = 1'b1; d_div = 1'b1; d_fun = F_DIVU; d_rs1 = 32'd50; d_rs2 = 32'd3; x_stall = 1'b1;
        @(posedge clk); #1;
        d_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rd_r1", 64'(rd[0]), 64'd0);
        chk("rst_mid_rd_r2", 64'(rd[1]), 64'd0);
        chk("rst_mid_ctl", 64'({stall_req, done}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        x_stall = 1'b0;

`ifdef URV_DIV_EARLY_OUT_EN
        run_op(F_DIVU, 32'd7, 32'd9, -1, 0, d0, d1, s0, s1);
        chk("eo_divu_rd", 64'(rd[0]), 64'd0);
        chk("eo_divu_stall", 64'(s0), 64'd2);
        op_lit("eo_remu", F_REMU, 32'd7, 32'd9, 32'd7);
        run_op(F_DIV, 32'd100, 32'd7, -1, 0, d0, d1, s0, s1);
        chk("eo_div_full_stall", 64'(s0), 64'd34);
`endif

        // Randomized operations with occasional kills and DONE holds
        for (int n = 0; n < 150; n++) begin
            logic [2:0] f;
            int ka;
            f  = {1'b1, 2'($urandom_range(0, 3))};
            ka = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 40)) : -1;
            run_op(f, pick(), pick(), ka, int'($urandom_range(0, 3)), d0, d1, s0, s1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
